// File: rtl/wb_pkg.sv
// Shared widths and entry type for the register-file writeback path.
// Defaults match a 32-entry, 64-bit register file.
// Holds no logic.
package wb_pkg;
  localparam int WB_DATA_W = 64;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DEPTH  = 4;

  // One pending register write: destination index plus value.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer that takes two writes per cycle (port 0 older, port 1 younger) and pops one entry per cycle.
// Latency: a written entry is visible on the age-ordered outputs the cycle after the write edge.
// No backpressure of its own: the caller must never write past DEPTH; a pop on empty is ignored.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr0_en_i,
  input  logic [ADDR_W-1:0] wr0_rd_i,
  input  logic [DATA_W-1:0] wr0_data_i,
  input  logic              wr1_en_i,
  input  logic [ADDR_W-1:0] wr1_rd_i,
  input  logic [DATA_W-1:0] wr1_data_i,
  input  logic              rd_en_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [ADDR_W-1:0] age_rd_o   [DEPTH],
  output logic [DATA_W-1:0] age_data_o [DEPTH],
  output logic [DEPTH-1:0]  age_vld_o
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr1_ptr;
  logic              deq;

  // The younger write lands just behind the older one, or at the tail if the older port is idle.
  assign wr1_ptr = tail_q + PTR_W'(wr0_en_i);
  assign deq     = rd_en_i && (count_q != '0);
  assign count_o = count_q;

  // Pointers wrap naturally (power-of-two depth); full vs empty is told apart by the count alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      tail_q  <= tail_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
      head_q  <= head_q + PTR_W'(deq);
      count_q <= count_q + CNT_W'(wr0_en_i) + CNT_W'(wr1_en_i) - CNT_W'(deq);
    end
  end

  // Entry storage needs no reset: slots beyond the count are never reported valid.
  always_ff @(posedge clk) begin
    if (!reset && wr0_en_i) begin
      rd_q[tail_q]   <= wr0_rd_i;
      data_q[tail_q] <= wr0_data_i;
    end
    if (!reset && wr1_en_i) begin
      rd_q[wr1_ptr]   <= wr1_rd_i;
      data_q[wr1_ptr] <= wr1_data_i;
    end
  end

  // Present entries oldest-first (index 0 is the head) so the forwarding search can take the last match.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_rd_o[i]   = rd_q[head_q + PTR_W'(i)];
      age_data_o[i] = data_q[head_q + PTR_W'(i)];
      age_vld_o[i]  = CNT_W'(i) < count_q;
    end
  end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into an in-order buffer and drains one register-file write per cycle.
// Latency: a result accepted at edge N is on the write port in cycle N+1; forwarding is combinational.
// Backpressure: readiness comes from the registered count only; loads get priority for the last free slot.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int DEPTH  = WB_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [ADDR_W-1:0]            mem_rd,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [ADDR_W-1:0]            alu_rd,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         reg_write,
  output logic [ADDR_W-1:0]            write_reg,
  output logic [DATA_W-1:0]            write_data,
  input  logic [ADDR_W-1:0]            fwd_reg1,
  input  logic [ADDR_W-1:0]            fwd_reg2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_W-1:0]            fwd_data1,
  output logic [DATA_W-1:0]            fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   wb_count
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  free;
  logic              mem_enq, alu_enq;
  logic [ADDR_W-1:0] age_rd   [DEPTH];
  logic [DATA_W-1:0] age_data [DEPTH];
  logic [DEPTH-1:0]  age_vld;

  assign free = CNT_W'(DEPTH) - count;

  // Ready is held high while reset is asserted so upstream sees the post-reset state immediately.
  assign mem_ready = reset || (free >= CNT_W'(1));
  assign alu_ready = reset || (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !mem_valid);

  // Writes to r0 complete the handshake but are dropped, so they never occupy a slot.
  assign mem_enq = !reset && mem_valid && mem_ready && (mem_rd != '0);
  assign alu_enq = !reset && alu_valid && alu_ready && (alu_rd != '0);

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr0_en_i   (mem_enq),
    .wr0_rd_i   (mem_rd),
    .wr0_data_i (mem_data),
    .wr1_en_i   (alu_enq),
    .wr1_rd_i   (alu_rd),
    .wr1_data_i (alu_data),
    .rd_en_i    (count != '0),
    .count_o    (count),
    .age_rd_o   (age_rd),
    .age_data_o (age_data),
    .age_vld_o  (age_vld)
  );

  assign reg_write  = !reset && age_vld[0];
  assign write_reg  = reg_write ? age_rd[0]   : '0;
  assign write_data = reg_write ? age_data[0] : '0;
  assign wb_count   = reset ? '0 : count;

  // Walk buffered entries oldest to youngest; a later match overrides, so the youngest value wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset && age_vld[i] && (fwd_reg1 != '0) && (age_rd[i] == fwd_reg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = age_data[i];
      end
      if (!reset && age_vld[i] && (fwd_reg2 != '0) && (age_rd[i] == fwd_reg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = age_data[i];
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed vector table, hand-written burst/reset sequences,
// and a randomized run, all compared against a queue-based model of the pending-write list.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_rd, alu_rd, fwd_reg1, fwd_reg2, write_reg;
  logic [63:0] mem_data, alu_data, write_data, fwd_data1, fwd_data2;
  logic        reg_write, fwd_hit1, fwd_hit2;
  logic [2:0]  wb_count;

  writeback_unit #(.DATA_W(64), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mv;  logic [4:0] mrd; logic [63:0] mdat;
    logic        av;  logic [4:0] ard; logic [63:0] adat;
    logic [4:0]  f1;  logic [4:0] f2;
    logic        rw;  logic [4:0] wr;  logic [63:0] wd;
    logic [2:0]  cnt; logic mr; logic ar;
    logic        h1;  logic [63:0] d1;
    logic        h2;  logic [63:0] d2;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  wb_entry_t   q[$];
  logic [4:0]  wlog[$];
  logic        last_mem_acc, last_alu_acc;
  logic        obs_mem_ready, obs_alu_ready;
  logic [2:0]  obs_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mv, input logic [4:0] mrd, input logic [63:0] mdat,
                       input logic av, input logic [4:0] ard, input logic [63:0] adat,
                       input logic [4:0] f1, input logic [4:0] f2);
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    fwd_reg1 = f1;  fwd_reg2 = f2;
  endtask

  // One clock: compare at negedge against the model (and optionally a table row), then advance the model.
  task automatic run_cycle(input bit use_row, input vec_t v);
    int          free;
    logic        e_mr, e_ar, e_h1, e_h2;
    logic [63:0] e_d1, e_d2;
    @(negedge clk);
    free = DEPTH - q.size();
    e_mr = reset || (free >= 1);
    e_ar = reset || (free >= 2) || (free >= 1 && !mem_valid);
    e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
    if (!reset) begin
      for (int i = 0; i < q.size(); i++) begin
        if (fwd_reg1 != 0 && q[i].rd == fwd_reg1) begin e_h1 = 1'b1; e_d1 = q[i].data; end
        if (fwd_reg2 != 0 && q[i].rd == fwd_reg2) begin e_h2 = 1'b1; e_d2 = q[i].data; end
      end
    end
    chk("reg_write",  64'(reg_write),  (!reset && q.size() > 0) ? 64'd1 : 64'd0);
    chk("write_reg",  64'(write_reg),  (!reset && q.size() > 0) ? 64'(q[0].rd) : 64'd0);
    chk("write_data", write_data,      (!reset && q.size() > 0) ? q[0].data : 64'd0);
    chk("wb_count",   64'(wb_count),   reset ? 64'd0 : 64'(q.size()));
    chk("mem_ready",  64'(mem_ready),  64'(e_mr));
    chk("alu_ready",  64'(alu_ready),  64'(e_ar));
    chk("fwd_hit1",   64'(fwd_hit1),   64'(e_h1));
    chk("fwd_data1",  fwd_data1,       e_d1);
    chk("fwd_hit2",   64'(fwd_hit2),   64'(e_h2));
    chk("fwd_data2",  fwd_data2,       e_d2);
    if (use_row) begin
      chk("row_reg_write",  64'(reg_write), 64'(v.rw));
      chk("row_write_reg",  64'(write_reg), 64'(v.wr));
      chk("row_write_data", write_data,     v.wd);
      chk("row_wb_count",   64'(wb_count),  64'(v.cnt));
      chk("row_mem_ready",  64'(mem_ready), 64'(v.mr));
      chk("row_alu_ready",  64'(alu_ready), 64'(v.ar));
      chk("row_fwd_hit1",   64'(fwd_hit1),  64'(v.h1));
      chk("row_fwd_data1",  fwd_data1,      v.d1);
      chk("row_fwd_hit2",   64'(fwd_hit2),  64'(v.h2));
      chk("row_fwd_data2",  fwd_data2,      v.d2);
    end
    if (reg_write) wlog.push_back(write_reg);
    obs_mem_ready = mem_ready; obs_alu_ready = alu_ready; obs_count = wb_count;
    last_mem_acc = mem_valid && e_mr && !reset;
    last_alu_acc = alu_valid && e_ar && !reset;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (q.size() > 0) void'(q.pop_front());
      if (last_mem_acc && mem_rd != 0) q.push_back('{rd: mem_rd, data: mem_data});
      if (last_alu_acc && alu_rd != 0) q.push_back('{rd: alu_rd, data: alu_data});
    end
    #1;
  endtask

  vec_t vt[14];
  vec_t none;
  logic [4:0] exp_order[6];

  initial begin
    none = '0;
    // mv mrd mdat | av ard adat | f1 f2 | rw wr wd | cnt mr ar | h1 d1 | h2 d2
    vt[0]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd5,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[1]  = '{1'b0,5'd0,64'h0,  1'b1,5'd5,64'hAB, 5'd5,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[2]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd5,5'd0, 1'b1,5'd5,64'hAB, 3'd1,1'b1,1'b1, 1'b1,64'hAB, 1'b0,64'h0};
    vt[3]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd5,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[4]  = '{1'b1,5'd7,64'h1,  1'b1,5'd8,64'h2,  5'd7,5'd8, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[5]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd8, 1'b1,5'd7,64'h1,  3'd2,1'b1,1'b1, 1'b1,64'h1,  1'b1,64'h2};
    vt[6]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd7,5'd8, 1'b1,5'd8,64'h2,  3'd1,1'b1,1'b1, 1'b0,64'h0,  1'b1,64'h2};
    vt[7]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[8]  = '{1'b1,5'd3,64'h11, 1'b1,5'd3,64'h22, 5'd0,5'd3, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[9]  = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd3, 1'b1,5'd3,64'h11, 3'd2,1'b1,1'b1, 1'b0,64'h0,  1'b1,64'h22};
    vt[10] = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd3, 1'b1,5'd3,64'h22, 3'd1,1'b1,1'b1, 1'b0,64'h0,  1'b1,64'h22};
    vt[11] = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[12] = '{1'b0,5'd0,64'h0,  1'b1,5'd0,64'hFF, 5'd0,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};
    vt[13] = '{1'b0,5'd0,64'h0,  1'b0,5'd0,64'h0,  5'd0,5'd0, 1'b0,5'd0,64'h0,  3'd0,1'b1,1'b1, 1'b0,64'h0,  1'b0,64'h0};

    // Reset held two cycles; the model expects idle outputs with both readies high.
    reset = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd5, 5'd0);
    run_cycle(1'b0, none);
    run_cycle(1'b0, none);
    reset = 1'b0;

    // Directed vector table: single write, dual write, same-register forwarding, r0 drop.
    foreach (vt[i]) begin
      drive(vt[i].mv, vt[i].mrd, vt[i].mdat, vt[i].av, vt[i].ard, vt[i].adat, vt[i].f1, vt[i].f2);
      run_cycle(1'b1, vt[i]);
    end

    // Burst: both sources stream three results each; the ALU stalls on the last slot and holds.
    begin
      int mi, ai;
      mi = 0; ai = 0;
      wlog.delete();
      exp_order = '{5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23};
      for (int c = 0; c < 16; c++) begin
        drive(mi < 3, 5'(11 + mi), 64'(100 + mi), ai < 3, 5'(21 + ai), 64'(200 + ai), 5'd0, 5'd0);
        run_cycle(1'b0, none);
        if (c == 2) begin
          chk("burst_c3_count",     64'(obs_count),     64'd3);
          chk("burst_c3_mem_ready", 64'(obs_mem_ready), 64'd1);
          chk("burst_c3_alu_ready", 64'(obs_alu_ready), 64'd0);
        end
        if (last_mem_acc) mi++;
        if (last_alu_acc) ai++;
      end
      chk("burst_write_total", 64'(wlog.size()), 64'd6);
      for (int i = 0; i < 6; i++)
        chk("burst_write_order", (i < wlog.size()) ? 64'(wlog[i]) : 64'hDEAD, 64'(exp_order[i]));
    end

    // Reset with three entries pending: nothing buffered may reach the write port afterwards.
    drive(1'b1, 5'd1, 64'h10, 1'b1, 5'd2, 64'h20, 5'd1, 5'd2);
    run_cycle(1'b0, none);
    drive(1'b1, 5'd3, 64'h30, 1'b1, 5'd4, 64'h40, 5'd1, 5'd2);
    run_cycle(1'b0, none);
    drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0, 5'd3, 5'd4);
    reset = 1'b1;
    run_cycle(1'b0, none);
    chk("pre_reset_count", 64'(obs_count), 64'd0);
    reset = 1'b0;
    wlog.delete();
    for (int c = 0; c < 4; c++) run_cycle(1'b0, none);
    chk("post_reset_no_write", 64'(wlog.size()), 64'd0);

    // Randomized traffic with small register range for collisions and r0, plus rare resets.
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      reset = ($urandom_range(0, 199) == 0);
      run_cycle(1'b0, none);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
